// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port Avalon-MM arbiter for the SDRAM controller slave, with starvation
// guard for port 1 and an in-order tag FIFO routing pipelined read responses back to their issuer.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 16,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [ADDR_W-1:0]              s0_address,
    input  logic                           s0_read,
    input  logic                           s0_write,
    input  logic [DATA_W-1:0]              s0_writedata,
    input  logic [DATA_W/8-1:0]            s0_byteenable,
    output logic                           s0_waitrequest,
    output logic [DATA_W-1:0]              s0_readdata,
    output logic                           s0_readdatavalid,
    input  logic [ADDR_W-1:0]              s1_address,
    input  logic                           s1_read,
    input  logic                           s1_write,
    input  logic [DATA_W-1:0]              s1_writedata,
    input  logic [DATA_W/8-1:0]            s1_byteenable,
    output logic                           s1_waitrequest,
    output logic [DATA_W-1:0]              s1_readdata,
    output logic                           s1_readdatavalid,
    output logic [ADDR_W-1:0]              avm_address,
    output logic                           avm_read,
    output logic                           avm_write,
    output logic [DATA_W-1:0]              avm_writedata,
    output logic [DATA_W/8-1:0]            avm_byteenable,
    input  logic                           avm_waitrequest,
    input  logic [DATA_W-1:0]              avm_readdata,
    input  logic                           avm_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]   pending_count,
    output logic                           err_unexpected_rdv
);
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state;
    logic                owner;
    logic [SW-1:0]       starve;
    logic [MAX_PENDING-1:0] tag;
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;

    logic can_read, elig0, elig1, pick1, accept, push, pop, empty;

    // Read+write together counts as a write, so writes never consult the FIFO space.
    assign can_read = pending_count < CNT_W'(MAX_PENDING);
    assign elig0    = s0_write || (s0_read && can_read);
    assign elig1    = s1_write || (s1_read && can_read);
    assign pick1    = elig1 && (starve == SW'(STARVE_LIMIT) || !elig0);
    assign accept   = state == ISSUE && !avm_waitrequest;
    assign push     = accept && avm_read;
    assign empty    = pending_count == '0;
    assign pop      = avm_readdatavalid && !empty;

    assign s0_waitrequest   = !(accept && !owner);
    assign s1_waitrequest   = !(accept && owner);
    assign s0_readdatavalid = pop && !tag[rptr];
    assign s1_readdatavalid = pop && tag[rptr];
    assign s0_readdata      = avm_readdata;
    assign s1_readdata      = avm_readdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            owner              <= 1'b0;
            avm_address        <= '0;
            avm_read           <= 1'b0;
            avm_write          <= 1'b0;
            avm_writedata      <= '0;
            avm_byteenable     <= '0;
            starve             <= '0;
            tag                <= '0;
            wptr               <= '0;
            rptr               <= '0;
            pending_count      <= '0;
            err_unexpected_rdv <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (elig0 || elig1) begin
                    state          <= ISSUE;
                    owner          <= pick1;
                    avm_address    <= pick1 ? s1_address : s0_address;
                    avm_writedata  <= pick1 ? s1_writedata : s0_writedata;
                    avm_byteenable <= pick1 ? s1_byteenable : s0_byteenable;
                    avm_read       <= pick1 ? (s1_read && !s1_write) : (s0_read && !s0_write);
                    avm_write      <= pick1 ? s1_write : s0_write;
                end
            end else if (accept) begin
                state     <= IDLE;
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end
            if (push) begin
                tag[wptr] <= owner;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            pending_count <= pending_count + CNT_W'(push) - CNT_W'(pop);
            if (accept && owner)
                starve <= '0;
            else if (elig1 && starve != SW'(STARVE_LIMIT))
                starve <= starve + 1'b1;
            if (avm_readdatavalid && empty)
                err_unexpected_rdv <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scenario tasks with a response scoreboard; the bench plays both
// requesters and the SDRAM controller.
module tb_sdram_port_arbiter;
    localparam int AW = 25, DW = 16, BW = DW / 8, MP = 8, SL = 16, CW = $clog2(MP) + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [AW-1:0] s0_address = '0, s1_address = '0;
    logic s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [DW-1:0] s0_writedata = '0, s1_writedata = '0;
    logic [BW-1:0] s0_byteenable = '0, s1_byteenable = '0;
    logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DW-1:0] s0_readdata, s1_readdata;
    logic [AW-1:0] avm_address;
    logic avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [BW-1:0] avm_byteenable;
    logic avm_waitrequest = 1'b0;
    logic [DW-1:0] avm_readdata = '0;
    logic avm_readdatavalid = 1'b0;
    logic [CW-1:0] pending_count;
    logic err_unexpected_rdv;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .pending_count(pending_count), .err_unexpected_rdv(err_unexpected_rdv)
    );

    typedef struct packed { logic port; logic [DW-1:0] data; } rsp_t;
    rsp_t exp_q[$];
    int checks = 0, passed = 0;
    bit auto_rsp = 1'b0, acc = 1'b0, acc_port = 1'b0, rsp_due = 1'b0;
    logic [DW-1:0] rsp_data = '0, next_data = '0;

    // Outputs are observed at the falling edge; every response strobe is matched against the queue.
    task automatic sample();
        rsp_t e;
        @(negedge clk);
        acc = !s0_waitrequest || !s1_waitrequest;
        acc_port = !s1_waitrequest;
        if (s0_readdatavalid || s1_readdatavalid) begin
            checks++;
            if (exp_q.size() == 0 || (s0_readdatavalid && s1_readdatavalid))
                $display("FAIL rsp_route: s0_rdv=%b s1_rdv=%b queued=%0d, required one strobe for a queued read",
                         s0_readdatavalid, s1_readdatavalid, exp_q.size());
            else begin
                e = exp_q.pop_front();
                if (s1_readdatavalid !== e.port || (e.port ? s1_readdata : s0_readdata) !== e.data)
                    $display("FAIL rsp_data: got port %0d data %h, required port %0d data %h",
                             s1_readdatavalid, e.port ? s1_readdata : s0_readdata, e.port, e.data);
                else passed++;
            end
        end
        if (auto_rsp && acc && avm_read) begin
            exp_q.push_back({acc_port, next_data});
            rsp_due = 1'b1;
            rsp_data = next_data;
            next_data++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            avm_readdatavalid = rsp_due;
            avm_readdata = rsp_data;
            rsp_due = 1'b0;
        end
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic do_reset();
        {s0_read, s0_write, s1_read, s1_write, avm_readdatavalid, avm_waitrequest} = '0;
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    // Drives one requester until its command is accepted, then drops the request.
    task automatic issue(input bit p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bit ok;
        n = 0;
        if (p) begin
            s1_address = a; s1_writedata = d; s1_byteenable = '1; s1_read = !wr; s1_write = wr;
        end else begin
            s0_address = a; s0_writedata = d; s0_byteenable = '1; s0_read = !wr; s0_write = wr;
        end
        do begin
            sample();
            ok = p ? !s1_waitrequest : !s0_waitrequest;
            if (ok && wr) begin
                checks++;
                if (avm_write !== 1'b1 || avm_writedata !== d || avm_address !== a || avm_byteenable !== '1)
                    $display("FAIL write_cmd: got wr=%b data=%h addr=%h be=%b, required 1 %h %h 11",
                             avm_write, avm_writedata, avm_address, avm_byteenable, d, a);
                else passed++;
            end
            adv();
            n++;
        end while (!ok && n < 50);
        checks++;
        if (!ok) $display("FAIL issue_timeout: port %0d not accepted in %0d cycles", p, n);
        else begin
            passed++;
            if (!wr) exp_q.push_back({p, d});
        end
        if (p) {s1_read, s1_write} = '0;
        else {s0_read, s0_write} = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle();
        sample();
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} !== '0)
            $display("FAIL reset_avm: got rd=%b wr=%b addr=%h wd=%h be=%b, required all zero",
                     avm_read, avm_write, avm_address, avm_writedata, avm_byteenable);
        else passed++;
        checks++;
        if ({s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid} !== 4'b1100)
            $display("FAIL reset_slave: got wait=%b%b rdv=%b%b, required wait=11 rdv=00",
                     s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid);
        else passed++;
        checks++;
        if (pending_count !== '0 || err_unexpected_rdv !== 1'b0)
            $display("FAIL reset_status: got pending=%0d err=%b, required 0 0", pending_count, err_unexpected_rdv);
        else passed++;
        adv();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        int lows;
        do_reset();
        lows = 0;
        avm_waitrequest = 1'b1;
        s0_address = 25'h0001234;
        s0_read = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) avm_waitrequest = 1'b0;
            sample();
            checks++;
            if (avm_address !== 25'h0001234 || avm_read !== 1'b1)
                $display("FAIL cmd_hold[%0d]: got addr=%h rd=%b, required 0001234 1", i, avm_address, avm_read);
            else passed++;
            if (!s0_waitrequest) lows++;
            adv();
        end
        s0_read = 1'b0;
        exp_q.push_back({1'b0, 16'hBEEF});
        sample();
        checks++;
        if (lows != 1 || s0_waitrequest !== 1'b1 || avm_read !== 1'b0)
            $display("FAIL single_accept: got wait_low_cycles=%0d wait=%b rd=%b, required 1 1 0",
                     lows, s0_waitrequest, avm_read);
        else passed++;
        adv();
        repeat (3) cycle();
        avm_readdatavalid = 1'b1;
        avm_readdata = 16'hBEEF;
        sample();
        checks++;
        if (s0_readdatavalid !== 1'b1 || s1_readdatavalid !== 1'b0 || s0_readdata !== 16'hBEEF)
            $display("FAIL single_rsp: got rdv=%b%b data=%h, required 10 beef",
                     s0_readdatavalid, s1_readdatavalid, s0_readdata);
        else passed++;
        adv();
        avm_readdatavalid = 1'b0;
    endtask

    task automatic test_starvation();
        int k, n;
        do_reset();
        auto_rsp = 1'b1;
        next_data = 16'h4000;
        s0_address = 25'h10; s1_address = 25'h20;
        s0_read = 1'b1; s1_read = 1'b1;
        k = 0; n = 0;
        while (k < 27 && n < 200) begin
            sample();
            if (acc) begin
                checks++;
                if (acc_port !== (k % 9 == 8))
                    $display("FAIL starve_order[%0d]: got port %0d, required port %0d", k, acc_port, k % 9 == 8);
                else passed++;
                k++;
            end
            adv();
            n++;
        end
        checks++;
        if (k < 27) $display("FAIL starve_timeout: got %0d accepts, required 27", k);
        else passed++;
        s0_read = 1'b0; s1_read = 1'b0;
        repeat (4) cycle();
        auto_rsp = 1'b0;
        avm_readdatavalid = 1'b0;
        checks++;
        if (exp_q.size() != 0) $display("FAIL starve_drain: got %0d responses missing, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_in_order();
        logic [DW-1:0] d [3];
        d = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        issue(0, 0, 25'h100, d[0]);
        issue(1, 0, 25'h200, d[1]);
        issue(0, 0, 25'h300, d[2]);
        sample();
        checks++;
        if (pending_count !== CW'(3)) $display("FAIL order_pending: got %0d, required 3", pending_count);
        else passed++;
        adv();
        for (int i = 0; i < 3; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = d[i];
            cycle();
            avm_readdatavalid = 1'b0;
            sample();
            checks++;
            if (pending_count !== CW'(2 - i)) $display("FAIL order_pending[%0d]: got %0d, required %0d", i, pending_count, 2 - i);
            else passed++;
            adv();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) issue(0, 0, AW'(i), DW'(16'h5000 + i));
        sample();
        checks++;
        if (pending_count !== CW'(8)) $display("FAIL full_pending: got %0d, required 8", pending_count);
        else passed++;
        adv();
        s0_address = 25'h9;
        s0_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if (s0_waitrequest !== 1'b1 || avm_read !== 1'b0)
                $display("FAIL full_block[%0d]: got wait=%b rd=%b, required 1 0", i, s0_waitrequest, avm_read);
            else passed++;
            adv();
        end
        issue(1, 1, 25'h77, 16'hCAFE);
        sample();
        checks++;
        if (s0_waitrequest !== 1'b1 || pending_count !== CW'(8))
            $display("FAIL full_after_write: got wait=%b pending=%0d, required 1 8", s0_waitrequest, pending_count);
        else passed++;
        adv();
        avm_readdatavalid = 1'b1;
        avm_readdata = 16'h5000;
        cycle();
        avm_readdatavalid = 1'b0;
        issue(0, 0, 25'h9, 16'h5008);
        for (int i = 1; i <= 8; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = DW'(16'h5000 + i);
            cycle();
        end
        avm_readdatavalid = 1'b0;
        sample();
        checks++;
        if (pending_count !== '0 || exp_q.size() != 0)
            $display("FAIL full_drain: got pending=%0d missing=%0d, required 0 0", pending_count, exp_q.size());
        else passed++;
        adv();
    endtask

    task automatic test_unexpected();
        do_reset();
        avm_readdatavalid = 1'b1;
        avm_readdata = 16'hDEAD;
        sample();
        checks++;
        if (s0_readdatavalid !== 1'b0 || s1_readdatavalid !== 1'b0)
            $display("FAIL unexp_strobe: got rdv=%b%b, required 00", s0_readdatavalid, s1_readdatavalid);
        else passed++;
        adv();
        avm_readdatavalid = 1'b0;
        sample();
        checks++;
        if (err_unexpected_rdv !== 1'b1 || pending_count !== '0)
            $display("FAIL unexp_flag: got err=%b pending=%0d, required 1 0", err_unexpected_rdv, pending_count);
        else passed++;
        adv();
        repeat (5) cycle();
        sample();
        checks++;
        if (err_unexpected_rdv !== 1'b1) $display("FAIL unexp_sticky: got %b, required 1", err_unexpected_rdv);
        else passed++;
        adv();
        do_reset();
        sample();
        checks++;
        if (err_unexpected_rdv !== 1'b0) $display("FAIL unexp_clear: got %b, required 0", err_unexpected_rdv);
        else passed++;
        adv();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(0, 0, 25'h1, 16'h0A01);
        issue(1, 0, 25'h2, 16'h0A02);
        issue(0, 0, 25'h3, 16'h0A03);
        avm_waitrequest = 1'b1;
        s0_address = 25'h55;
        s0_read = 1'b1;
        cycle();
        sample();
        checks++;
        if (avm_read !== 1'b1 || pending_count !== CW'(3))
            $display("FAIL mid_setup: got rd=%b pending=%0d, required 1 3", avm_read, pending_count);
        else passed++;
        adv();
        reset_n = 1'b0;
        s0_read = 1'b0;
        cycle();
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        exp_q.delete();
        sample();
        checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0 || pending_count !== '0 ||
            s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b1)
            $display("FAIL mid_reset: got rd=%b wr=%b pending=%0d wait=%b%b, required 0 0 0 11",
                     avm_read, avm_write, pending_count, s0_waitrequest, s1_waitrequest);
        else passed++;
        adv();
        issue(1, 0, 25'h66, 16'h6666);
        avm_readdatavalid = 1'b1;
        avm_readdata = 16'h6666;
        cycle();
        avm_readdatavalid = 1'b0;
        sample();
        checks++;
        if (pending_count !== '0 || exp_q.size() != 0)
            $display("FAIL mid_fifo: got pending=%0d missing=%0d, required 0 0", pending_count, exp_q.size());
        else passed++;
        adv();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_starvation();
        test_in_order();
        test_full();
        test_unexpected();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
